// File: rtl/regbank_sweep_if.sv
// regbank_sweep_if
//   Bus bundle between the decode stage and the register bank.
//   master : decode/datapath side (drives indices, write data, ops)
//   slave  : register bank side (drives read data and status)
//   Signals:
//     sr1, sr2      read indices
//     rData1/2      combinational read data
//     dr, wrData    write index / write data
//     write         write enable
//     sp_op         00 none, 01 SP+=STEP, 10 SP-=STEP, 11 none
//     pc_inc        PC+=STEP
//     clr_req       start clear sweep
//     busy          sweep in progress
//     clr_done      one-cycle pulse at sweep completion
//     addr_err      sticky out-of-range write flag
interface regbank_sweep_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] sr1;
  logic [ADDR_W-1:0] sr2;
  logic [DATA_W-1:0] rData1;
  logic [DATA_W-1:0] rData2;
  logic [ADDR_W-1:0] dr;
  logic [DATA_W-1:0] wrData;
  logic              write;
  logic [1:0]        sp_op;
  logic              pc_inc;
  logic              clr_req;
  logic              busy;
  logic              clr_done;
  logic              addr_err;

  modport master (
    output sr1, sr2, dr, wrData, write, sp_op, pc_inc, clr_req,
    input  rData1, rData2, busy, clr_done, addr_err
  );

  modport slave (
    input  sr1, sr2, dr, wrData, write, sp_op, pc_inc, clr_req,
    output rData1, rData2, busy, clr_done, addr_err
  );
endinterface

// File: rtl/regbank_sweep.sv
// regbank_sweep
//   Parametrised register bank: GPR_N general-purpose registers plus
//   SP (index GPR_N) and PC (index GPR_N+1). Two combinational read
//   ports, one write port, hardware SP inc/dec and PC increment, and a
//   clear sequencer that rewrites one entry per cycle with its reset
//   value while reporting busy / clr_done.
//   Ports:
//     clk    clock, all state changes on rising edge
//     reset  asynchronous active-low reset
//     bus    regbank_sweep_if.slave (read/write/op/status signals)
//   Optional build macro:
//     REGBANK_BYPASS_EN  same-cycle write-through forwarding to both
//                        read ports; undefined by default.
module regbank_sweep #(
  parameter int                DATA_W  = 32,
  parameter int                GPR_N   = 16,
  parameter int                ADDR_W  = 5,
  parameter logic [DATA_W-1:0] SP_INIT = '0,
  parameter logic [DATA_W-1:0] PC_INIT = '0,
  parameter int                STEP    = 4
) (
  input logic            clk,
  input logic            reset,
  regbank_sweep_if.slave bus
);

  localparam int                NREGS    = GPR_N + 2;
  localparam logic [ADDR_W-1:0] SP_IDX   = ADDR_W'(GPR_N);
  localparam logic [ADDR_W-1:0] PC_IDX   = ADDR_W'(GPR_N + 1);
  // Range checks compare against the last valid index so that NREGS
  // never has to fit in ADDR_W bits.
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NREGS - 1);
  localparam logic [DATA_W-1:0] STEP_D   = DATA_W'(STEP);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SWEEP = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  logic [DATA_W-1:0] regs [NREGS];
  logic [1:0]        state;
  logic [ADDR_W-1:0] ptr;
  logic              busy_i;
  logic              wr_ok;
  logic              wr_bad;
  logic              sp_written;
  logic              pc_written;
  logic [DATA_W-1:0] rd1;
  logic [DATA_W-1:0] rd2;

  assign busy_i     = (state == ST_SWEEP);
  assign wr_ok      = bus.write && !busy_i && (bus.dr <= LAST_IDX);
  assign wr_bad     = bus.write && !busy_i && (bus.dr >  LAST_IDX);
  assign sp_written = wr_ok && (bus.dr == SP_IDX);
  assign pc_written = wr_ok && (bus.dr == PC_IDX);

  // Clear sequencer: IDLE -> SWEEP on request, walk ptr across every
  // entry, then a single DONE cycle before returning to IDLE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
      ptr   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.clr_req) begin
            state <= ST_SWEEP;
            ptr   <= '0;
          end
        end
        ST_SWEEP: begin
          if (ptr == LAST_IDX) begin
            state <= ST_DONE;
            ptr   <= '0;
          end else begin
            ptr <= ptr + ADDR_W'(1);
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: begin
          state <= ST_IDLE;
          ptr   <= '0;
        end
      endcase
    end
  end

  // Register storage. The sweep owns the bank while busy; otherwise the
  // write port has priority over sp_op/pc_inc for the SP/PC entries.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < GPR_N; i++) begin
        regs[i] <= '0;
      end
      regs[GPR_N]     <= SP_INIT;
      regs[GPR_N + 1] <= PC_INIT;
    end else if (busy_i) begin
      if (ptr == SP_IDX) begin
        regs[ptr] <= SP_INIT;
      end else if (ptr == PC_IDX) begin
        regs[ptr] <= PC_INIT;
      end else begin
        regs[ptr] <= '0;
      end
    end else begin
      if (wr_ok) begin
        regs[bus.dr] <= bus.wrData;
      end
      if (!sp_written) begin
        if (bus.sp_op == 2'b01) begin
          regs[GPR_N] <= regs[GPR_N] + STEP_D;
        end else if (bus.sp_op == 2'b10) begin
          regs[GPR_N] <= regs[GPR_N] - STEP_D;
        end
      end
      if (bus.pc_inc && !pc_written) begin
        regs[GPR_N + 1] <= regs[GPR_N + 1] + STEP_D;
      end
    end
  end

  // Sticky error: only a dropped (out-of-range, not busy) write sets it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.addr_err <= 1'b0;
    end else if (wr_bad) begin
      bus.addr_err <= 1'b1;
    end
  end

  // Read ports; indices past the bank read as zero.
  always_comb begin
    rd1 = '0;
    rd2 = '0;
    if (bus.sr1 <= LAST_IDX) begin
      rd1 = regs[bus.sr1];
    end
    if (bus.sr2 <= LAST_IDX) begin
      rd2 = regs[bus.sr2];
    end
`ifdef REGBANK_BYPASS_EN
    // Write-through of the port write only; SP/PC arithmetic is not forwarded.
    if (wr_ok && (bus.sr1 == bus.dr)) begin
      rd1 = bus.wrData;
    end
    if (wr_ok && (bus.sr2 == bus.dr)) begin
      rd2 = bus.wrData;
    end
`endif
  end

  assign bus.rData1   = rd1;
  assign bus.rData2   = rd2;
  assign bus.busy     = busy_i;
  assign bus.clr_done = (state == ST_DONE);

endmodule

// File: tb/tb_regbank_sweep.sv
// tb_regbank_sweep
//   Self-checking bench for regbank_sweep (default parameters).
//   Keeps a reference model of the bank (array + sweep position) and
//   compares every read port and status output against it after each
//   directed step and during a randomized phase.
//   Honours REGBANK_BYPASS_EN when computing same-cycle read values.
module tb_regbank_sweep;

  localparam int          DATA_W  = 32;
  localparam int          GPR_N   = 16;
  localparam int          ADDR_W  = 5;
  localparam int          NREGS   = GPR_N + 2;
  localparam int          SP      = GPR_N;
  localparam int          PC      = GPR_N + 1;
  localparam logic [31:0] SP_INIT = 32'h0;
  localparam logic [31:0] PC_INIT = 32'h0;
  localparam logic [31:0] STEP    = 32'd4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  regbank_sweep_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  regbank_sweep #(
    .DATA_W (DATA_W),
    .GPR_N  (GPR_N),
    .ADDR_W (ADDR_W),
    .SP_INIT(SP_INIT),
    .PC_INIT(PC_INIT),
    .STEP   (4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [31:0] mReg [NREGS];
  bit          mSweep;
  int          mPos;
  bit          mDone;
  bit          mErr;

  function automatic logic [31:0] resetValue(int idx);
    if (idx == SP) return SP_INIT;
    if (idx == PC) return PC_INIT;
    return 32'h0;
  endfunction

  task automatic resetModel();
    for (int i = 0; i < NREGS; i++) mReg[i] = resetValue(i);
    mSweep = 0;
    mPos   = 0;
    mDone  = 0;
    mErr   = 0;
  endtask

  function automatic logic [31:0] expRead(logic [4:0] sr);
    logic [31:0] v;
    v = (int'(sr) < NREGS) ? mReg[int'(sr)] : 32'h0;
`ifdef REGBANK_BYPASS_EN
    if (bus.write && !mSweep && int'(bus.dr) < NREGS && sr == bus.dr) v = bus.wrData;
`endif
    return v;
  endfunction

  task automatic applyStimulus(input bit wr, input logic [4:0] d, input logic [31:0] wd,
                               input logic [1:0] sp, input bit pc, input bit clr,
                               input logic [4:0] s1, input logic [4:0] s2);
    bus.write   = wr;
    bus.dr      = d;
    bus.wrData  = wd;
    bus.sp_op   = sp;
    bus.pc_inc  = pc;
    bus.clr_req = clr;
    bus.sr1     = s1;
    bus.sr2     = s2;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, ".rData1"}, bus.rData1, expRead(bus.sr1));
    checkOutput({tag, ".rData2"}, bus.rData2, expRead(bus.sr2));
    checkOutput({tag, ".busy"}, {31'h0, bus.busy}, {31'h0, mSweep});
    checkOutput({tag, ".clr_done"}, {31'h0, bus.clr_done}, {31'h0, mDone});
    checkOutput({tag, ".addr_err"}, {31'h0, bus.addr_err}, {31'h0, mErr});
  endtask

  // Reads every index (including out-of-range ones) with idle controls.
  task automatic readAll(input string tag);
    for (int i = 0; i < 32; i++) begin
      applyStimulus(0, 5'd0, 32'h0, 2'b00, 0, 0, 5'(i), 5'((i + 7) % 32));
      checkAll(tag);
    end
  endtask

  // Advances one clock, applying the bank's rules to the model with the
  // inputs currently on the bus.
  task automatic clockCycle();
    logic [31:0] nReg [NREGS];
    bit nSweep, nDone, nErr;
    int nPos;
    nReg   = mReg;
    nSweep = mSweep;
    nPos   = mPos;
    nDone  = 0;
    nErr   = mErr;
    if (mSweep) begin
      nReg[mPos] = resetValue(mPos);
      nPos = mPos + 1;
      if (nPos == NREGS) begin
        nSweep = 0;
        nDone  = 1;
      end
    end else begin
      if (!mDone && bus.clr_req) begin
        nSweep = 1;
        nPos   = 0;
      end
      if (bus.write) begin
        if (int'(bus.dr) < NREGS) nReg[int'(bus.dr)] = bus.wrData;
        else nErr = 1;
      end
      if (!(bus.write && int'(bus.dr) == SP)) begin
        if (bus.sp_op == 2'b01) nReg[SP] = mReg[SP] + STEP;
        if (bus.sp_op == 2'b10) nReg[SP] = mReg[SP] - STEP;
      end
      if (bus.pc_inc && !(bus.write && int'(bus.dr) == PC)) nReg[PC] = mReg[PC] + STEP;
    end
    @(posedge clk);
    #1;
    mReg   = nReg;
    mSweep = nSweep;
    mPos   = nPos;
    mDone  = nDone;
    mErr   = nErr;
  endtask

  initial begin
    int busyCycles;
    resetModel();
    applyStimulus(0, 5'd0, 32'h0, 2'b00, 0, 0, 5'd0, 5'd0);

    // Reset state and full read-back
    repeat (2) @(posedge clk);
    #1;
    checkAll("reset_held");
    reset = 1'b1;
    readAll("after_reset");
    checkOutput("sp_init", bus.rData1, expRead(5'd0));

    // Write R1/R2, including the same-cycle read of the written index
    @(negedge clk);
    applyStimulus(1, 5'd1, 32'd50000, 2'b00, 0, 0, 5'd1, 5'd2);
    checkAll("wr_r1_same_cycle");
    clockCycle();
    applyStimulus(1, 5'd2, 32'd100000, 2'b00, 0, 0, 5'd1, 5'd2);
    checkAll("wr_r2_same_cycle");
    clockCycle();
    applyStimulus(0, 5'd0, 32'h0, 2'b00, 0, 0, 5'd1, 5'd2);
    checkOutput("r1_value", bus.rData1, 32'd50000);
    checkOutput("r2_value", bus.rData2, 32'd100000);

    // SP decrement wraps, PC write beats pc_inc, then pc_inc alone
    applyStimulus(0, 5'd0, 32'h0, 2'b10, 0, 0, 5'd16, 5'd17);
    clockCycle();
    applyStimulus(0, 5'd0, 32'h0, 2'b00, 0, 0, 5'd16, 5'd17);
    checkOutput("sp_wrap", bus.rData1, 32'hFFFF_FFFC);
    applyStimulus(1, 5'd17, 32'h100, 2'b00, 1, 0, 5'd16, 5'd17);
    clockCycle();
    applyStimulus(0, 5'd0, 32'h0, 2'b00, 0, 0, 5'd16, 5'd17);
    checkOutput("pc_write_wins", bus.rData2, 32'h100);
    applyStimulus(0, 5'd0, 32'h0, 2'b00, 1, 0, 5'd16, 5'd17);
    clockCycle();
    applyStimulus(0, 5'd0, 32'h0, 2'b00, 0, 0, 5'd16, 5'd17);
    checkOutput("pc_inc", bus.rData2, 32'h104);
    checkAll("sp_pc");

    // Out-of-range write: dropped, sticky addr_err
    applyStimulus(1, 5'd20, 32'hDEAD_BEEF, 2'b00, 0, 0, 5'd20, 5'd1);
    clockCycle();
    checkOutput("addr_err_set", {31'h0, bus.addr_err}, 32'h1);
    readAll("after_bad_write");
    @(negedge clk);
    applyStimulus(1, 5'd5, 32'h5555, 2'b00, 0, 0, 5'd5, 5'd0);
    clockCycle();
    applyStimulus(0, 5'd0, 32'h0, 2'b00, 0, 0, 5'd5, 5'd0);
    checkOutput("addr_err_sticky", {31'h0, bus.addr_err}, 32'h1);
    checkAll("after_good_write");

    // Fill the bank, then sweep with an ignored R3 write mid-sweep
    for (int i = 0; i < NREGS; i++) begin
      applyStimulus(1, 5'(i), $urandom | 32'h1, 2'b00, 0, 0, 5'(i), 5'd3);
      clockCycle();
    end
    applyStimulus(0, 5'd0, 32'h0, 2'b00, 0, 1, 5'd0, 5'd3);
    clockCycle();
    busyCycles = 0;
    for (int c = 0; c < 40 && bus.busy; c++) begin
      if (c == 10) applyStimulus(1, 5'd3, 32'hCAFE_F00D, 2'b01, 1, 1, 5'(c % NREGS), 5'd3);
      else applyStimulus(0, 5'd0, 32'h0, 2'b00, 0, 0, 5'(c % NREGS), 5'd3);
      checkAll("sweep");
      busyCycles++;
      clockCycle();
    end
    checkOutput("sweep_busy_cycles", 32'(busyCycles), 32'(NREGS));
    checkOutput("sweep_done_pulse", {31'h0, bus.clr_done}, 32'h1);
    applyStimulus(0, 5'd0, 32'h0, 2'b00, 0, 1, 5'd3, 5'd16);
    checkAll("done_cycle");
    clockCycle();
    checkOutput("done_one_cycle", {31'h0, bus.clr_done}, 32'h0);
    checkOutput("clr_in_done_ignored", {31'h0, bus.busy}, 32'h0);
    applyStimulus(0, 5'd0, 32'h0, 2'b00, 0, 0, 5'd3, 5'd16);
    checkOutput("r3_cleared", bus.rData1, 32'h0);
    readAll("after_sweep");

    // Reset mid-sweep, then restart from entry 0
    @(negedge clk);
    applyStimulus(1, 5'd0, 32'h1111, 2'b00, 0, 0, 5'd0, 5'd1);
    clockCycle();
    applyStimulus(1, 5'd1, 32'h2222, 2'b00, 0, 0, 5'd0, 5'd1);
    clockCycle();
    applyStimulus(0, 5'd0, 32'h0, 2'b00, 0, 1, 5'd0, 5'd1);
    clockCycle();
    applyStimulus(0, 5'd0, 32'h0, 2'b00, 0, 0, 5'd0, 5'd1);
    repeat (5) clockCycle();
    reset = 1'b0;
    #1;
    resetModel();
    checkOutput("midsweep_reset_busy", {31'h0, bus.busy}, 32'h0);
    readAll("midsweep_reset");
    @(negedge clk);
    reset = 1'b1;
    applyStimulus(1, 5'd0, 32'h3333, 2'b00, 0, 0, 5'd0, 5'd1);
    clockCycle();
    applyStimulus(1, 5'd1, 32'h4444, 2'b00, 0, 0, 5'd0, 5'd1);
    clockCycle();
    applyStimulus(0, 5'd0, 32'h0, 2'b00, 0, 1, 5'd0, 5'd1);
    clockCycle();
    for (int c = 0; c < NREGS + 2; c++) begin
      applyStimulus(0, 5'd0, 32'h0, 2'b00, 0, 0, 5'd0, 5'd1);
      checkAll("restart_sweep");
      clockCycle();
    end

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      applyStimulus(($urandom_range(0, 2) != 0), 5'($urandom_range(0, 31)), $urandom,
                    2'($urandom_range(0, 3)), bit'($urandom_range(0, 1)),
                    ($urandom_range(0, 24) == 0),
                    5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
      checkAll("random");
      clockCycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/regbank_sweep.md
# regbank_sweep

Parametrised successor to the 18-entry register bank.
- Configurable data width and general-purpose register (GPR) count, plus dedicated SP and PC registers.
- Two combinational read ports and one write port.
- Hardware SP increment/decrement and PC increment.
- Multi-cycle clear sequencer that zeroes the bank one entry per cycle and reports busy/done.
- Sits between the datapath decode stage and the ALU/memory stages of the processor.

## Interface
Parameters:
- DATA_W, 32, register width in bits
- GPR_N, 16, number of GPRs; indices 0..GPR_N-1
- ADDR_W, 5, index width; must satisfy 2^ADDR_W >= GPR_N+2
- SP_INIT, 0, SP value after reset and after a sweep
- PC_INIT, 0, PC value after reset and after a sweep
- STEP, 4, SP adjust and PC increment amount

Index map: SP = GPR_N, PC = GPR_N+1, NREGS = GPR_N+2.

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- sr1, sr2  in  ADDR_W  read indices
- rData1, rData2  out  DATA_W  read data (combinational)
- dr  in  ADDR_W  write index
- wrData  in  DATA_W  write data
- write  in  1  write enable
- sp_op  in  2  00 none, 01 SP+=STEP, 10 SP-=STEP, 11 none
- pc_inc  in  1  PC+=STEP
- clr_req  in  1  start clear sweep
- busy  out  1  sweep in progress
- clr_done  out  1  one-cycle pulse when sweep completes
- addr_err  out  1  sticky flag: out-of-range write attempted

## Operation
- Reads:
  - rData = entry[sr] when sr < NREGS, else 0.
  - Reads are never blocked; during a sweep they return the current, partially cleared contents.
- Write:
  - When write=1, not busy and dr < NREGS: entry[dr] <= wrData at the edge.
  - When write=1, not busy and dr >= NREGS: the write is dropped and addr_err is set. addr_err is cleared only by reset.
- SP/PC update priority, same edge:
  - Explicit write to the SP index overrides sp_op.
  - Explicit write to the PC index overrides pc_inc.
  - sp_op and pc_inc act independently of each other and of GPR writes.
- Arithmetic is modulo 2^DATA_W: SP wraps 0 -> 2^DATA_W-STEP on decrement; PC and SP wrap to low values on overflow. No flag is raised on wrap.
- Clear FSM states: IDLE, SWEEP, DONE.
  - IDLE: clr_req=1 -> SWEEP, ptr=0.
  - SWEEP:
    - Each edge writes entry[ptr] <= 0, or SP_INIT/PC_INIT at the SP/PC indices, then ptr++.
    - When ptr == NREGS-1 -> DONE.
  - DONE: clr_done=1 for one cycle -> IDLE.
  - busy = (state == SWEEP).
- While busy, write, sp_op and pc_inc are ignored; out-of-range writes do not set addr_err. clr_req is ignored unless in IDLE, including in DONE.
- Reset (reset=0) at any time, including mid-sweep: FSM -> IDLE, ptr=0, GPRs=0, SP=SP_INIT, PC=PC_INIT, busy=0, clr_done=0, addr_err=0.

## Timing
- Read latency: 0 cycles (combinational from sr and stored state).
- Write latency: visible on rData from the cycle after the write edge. Same-cycle forwarding depends on the configuration below.
- Sweep:
  - clr_req sampled high at edge E: busy=1 from E.
  - Entries cleared at edges E+1 .. E+NREGS.
  - At E+NREGS: busy=0 and clr_done=1, held until edge E+NREGS+1.
  - Total NREGS+1 cycles from request to IDLE.
- Outputs after reset: busy=0, clr_done=0, addr_err=0. rData = 0 for GPR indices, SP_INIT/PC_INIT for SP/PC.

## Configuration
- REGBANK_BYPASS_EN defined:
  - If write=1, not busy, dr < NREGS and sr == dr, then rData = wrData in the same cycle (write-through forwarding).
  - Applies to both read ports.
  - No forwarding of sp_op or pc_inc results.
- Undefined: rData shows the old contents until the edge after the write.

## Test plan
- Reset then read: reset low then high, read every index -> GPRs 0, SP=SP_INIT, PC=PC_INIT, indices >= NREGS read 0.
- Write/read: write 50000 to R1 and 100000 to R2, then sr1=1, sr2=2 -> 50000/100000. With REGBANK_BYPASS_EN, the same-cycle read equals wrData; without it, the same-cycle read shows the old value.
- SP/PC: with SP_INIT=0, sp_op=10 -> SP=0xFFFFFFFC. pc_inc=1 together with write PC=0x100 -> PC=0x100 (write wins). pc_inc alone next cycle -> 0x104.
- Bad write: dr=20 (GPR_N=16), write=1 -> no entry changes, addr_err=1 and stays 1 through later valid writes.
- Sweep: fill all entries, pulse clr_req -> busy high for exactly NREGS cycles, one-cycle clr_done, all entries cleared. A write to R3 during the sweep is ignored.
- Reset mid-sweep: assert reset 5 cycles into the sweep -> busy=0 immediately, all entries at reset values, a new clr_req restarts the sweep from ptr=0.
